cache_fill_fsm: RTL
===================

Name: cache_fill_fsm

Overview:
Cache-miss line-fill controller sitting directly downstream of the pipelined cpu's I-fetch / D-access path, between the cache arrays and the multi-cycle main memory.
- On a miss it issues one word request per cycle for the whole 16-byte line.
- It counts memory returns and drives the data-array and tag-array write strobes.
- It holds busy (pipeline stall source) until the line is installed.

Parameters:
LINE_WORDS, 8, 16-bit words per cache line; power of two, 2..16
IDX_W, 3, log2(LINE_WORDS); width of word index and counters
ADDR_W, 16, byte address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
miss_detected  in  1  cache reports a miss this cycle; sampled only in IDLE
miss_address  in  ADDR_W  byte address that missed
memory_data_valid  in  1  memory returns one word this cycle, in request order
memory_data  in  16  returned word
fsm_busy  out  1  fill in progress; cpu stalls while high
mem_en  out  1  memory read request strobe
memory_address  out  ADDR_W  byte address of the current request
write_data_array  out  1  write fill_data into the data array at fill_word
write_tag_array  out  1  install tag/valid for fill_line_addr
fill_word  out  IDX_W  word index within the line for the current data write
fill_data  out  16  word to write; equals memory_data
fill_line_addr  out  ADDR_W  latched line base address

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE.
  - issue_cnt, recv_cnt, base = 0.
  - All outputs 0.
  - Reset mid-fill aborts the fill immediately; no partial tag write.
- States: IDLE, FILL.
- IDLE:
  - fsm_busy = 0, mem_en = 0, write strobes = 0.
  - memory_data_valid is ignored, so stray returns from an aborted fill are dropped.
  - If miss_detected: latch base = miss_address with the low log2(2*LINE_WORDS) bits cleared (e.g. 0x1236 -> 0x1230); clear both counters; go to FILL next edge.
- FILL:
  - fsm_busy = 1. fill_line_addr = base.
  - Issue side: while issue_cnt < LINE_WORDS:
    - mem_en = 1, memory_address = base + 2*issue_cnt.
    - issue_cnt increments each cycle.
    - Requests are back-to-back and never gated by returns.
    - Once all LINE_WORDS are issued, mem_en = 0.
  - Receive side, each cycle memory_data_valid = 1:
    - write_data_array = 1, fill_word = recv_cnt, fill_data = memory_data.
    - recv_cnt increments.
    - Returns may arrive with gaps and may overlap issue; only valids are counted, never cycles.
  - Last word (memory_data_valid with recv_cnt == LINE_WORDS-1): write_tag_array = 1 in the same cycle as the final write_data_array; next state IDLE.
  - Timing: fsm_busy falls the cycle after the final write. A miss_detected in that IDLE cycle starts a new fill.
- Latency:
  - miss_detected sampled at edge N -> first mem_en at cycle N+1.
  - With a 4-cycle memory, returns occur in cycles N+5..N+12.
  - write_tag_array at N+12; fsm_busy low at N+13.
- miss_detected while in FILL is ignored; no queueing. The cpu re-presents the miss after the stall.
- Address arithmetic: width ADDR_W, modulo 2^ADDR_W. Base is line-aligned, so base + 2*issue_cnt never carries out of the line.
- memory_data_valid in FILL after recv_cnt reaches LINE_WORDS cannot occur, because the state has already left FILL.
- Outputs mem_en, memory_address, write_data_array, write_tag_array and fill_* are combinational from state/counters/inputs. The counters, base and state are registers.

Test Plan:
1. Miss at 0x1236, 4-cycle memory -> mem_en high 8 consecutive cycles with addresses 0x1230,0x1232,...,0x123E; fill_line_addr = 0x1230; fsm_busy high from cycle after miss until cycle after tag write.
2. Contiguous returns 0xA000..0xA007 -> 8 write_data_array pulses, fill_word 0..7 paired with matching fill_data; write_tag_array only on the 8th; fsm_busy drops next cycle.
3. Gapped returns (valid pattern 1,0,1,1,0,0,1,1,1,1,0,1) -> exactly 8 writes, indices 0..7 in order; tag write coincides with the 8th valid; no write in gap cycles.
4. miss_detected held high through the whole fill, then miss at 0x2000 one cycle after busy drops -> no restart during fill; second fill issues 0x2000..0x200E.
5. rst_n low after 3 returns -> all outputs 0 immediately (asynchronous); remaining 5 valids after release produce no writes and no tag write; next miss starts fresh at fill_word 0.
6. Miss at 0xFFFA -> base 0xFFF0, requests 0xFFF0..0xFFFE, no address wrap into 0x0000.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Cache-miss line-fill controller.
// On a miss it latches the line base address, issues one word read per cycle
// for the whole line, counts memory returns (which may be gapped and may
// overlap issue), writes each returned word into the data array and installs
// the tag together with the final word. fsm_busy stalls the cpu meanwhile.
module cache_fill_fsm #(
  parameter int LINE_WORDS = 8,   // 16-bit words per line, power of two 2..16
  parameter int IDX_W      = 3,   // log2(LINE_WORDS)
  parameter int ADDR_W     = 16   // byte address width
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic              fsm_busy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [IDX_W-1:0]  fill_word,
  output logic [15:0]       fill_data,
  output logic [ADDR_W-1:0] fill_line_addr
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // The issue counter needs one extra bit so it can hold LINE_WORDS,
  // meaning "every request of this line has been issued".
  localparam logic [IDX_W:0]    LINE_CNT  = (IDX_W+1)'(LINE_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);
  // A line spans 2*LINE_WORDS bytes; clearing these bits gives the line base.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(2 * LINE_WORDS - 1);

  state_t              state, state_next;
  logic [IDX_W:0]      issue_cnt, issue_next;
  logic [IDX_W-1:0]    recv_cnt, recv_next;
  logic [ADDR_W-1:0]   base, base_next;

  // State, counters and latched line base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_next;
      issue_cnt <= issue_next;
      recv_cnt  <= recv_next;
      base      <= base_next;
    end
  end

  // Next-state logic and combinational outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_next       = state;
    issue_next       = issue_cnt;
    recv_next        = recv_cnt;
    base_next        = base;
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_word        = '0;
    fill_data        = '0;
    fill_line_addr   = '0;

    case (state)
      IDLE: begin
        // Returns arriving here belong to an aborted fill and are dropped.
        if (miss_detected) begin
          base_next  = miss_address & LINE_MASK;
          issue_next = '0;
          recv_next  = '0;
          state_next = FILL;
        end
      end

      FILL: begin
        fsm_busy       = 1'b1;
        fill_line_addr = base;

        // Requests go out back-to-back, independent of returns. The base is
        // line-aligned, so adding the word offset never carries out of the line.
        if (issue_cnt < LINE_CNT) begin
          mem_en         = 1'b1;
          memory_address = base + ADDR_W'({issue_cnt, 1'b0});
          issue_next     = issue_cnt + (IDX_W+1)'(1);
        end

        // Only valid returns advance the receive count, never idle cycles.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_word        = recv_cnt;
          fill_data        = memory_data;
          recv_next        = recv_cnt + IDX_W'(1);
          if (recv_cnt == LAST_IDX) begin
            write_tag_array = 1'b1;
            state_next      = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
